nibble_insn_tx: RTL and testbench
=================================

Name: nibble_insn_tx

Overview:
- Host-side transmitter for the 4-bit nibble instruction-load protocol used by the PCPI bridge.
- Accepts a 32-bit instruction word over a valid/ready handshake and serialises it as 8 nibbles, least-significant first, using the send/ack strobe pair.
- After the last nibble it waits for the coprocessor completion indication, then reports success or timeout.
- Sits in test harnesses and in any on-chip master that loads instructions into the nibble receiver.

Parameters:
- NIBBLES, 8, nibbles per word; the data width is 4*NIBBLES.
- ACK_TIMEOUT, 255, max cycles in DRIVE waiting for ack_in before abort.
- DONE_TIMEOUT, 4095, max cycles in WAIT_DONE waiting for done_in before abort.
- TMR_W, 12, timer width; must hold max(ACK_TIMEOUT, DONE_TIMEOUT).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  instruction word offered
- in_ready  out  1  transmitter can accept a word (IDLE only)
- in_data  in  32  instruction word; captured when in_valid && in_ready
- nib_out  out  4  current nibble (to receiver segment input)
- send_out  out  1  nibble-present strobe (to receiver send input)
- ack_in  in  1  receiver has-captured indication (receiver's "received" output)
- done_in  in  1  coprocessor completion (pcpi_ready equivalent)
- busy  out  1  high in any state other than IDLE
- resp_valid  out  1  one-cycle pulse: transfer finished
- resp_timeout  out  1  qualifies resp_valid: 1 = aborted on timeout

Behaviour:
- Reset: all outputs 0, except in_ready=1; state IDLE, shift register 0, nibble index 0, timer 0. Outputs are registered (in_ready and busy are decoded from state).
- IDLE: in_ready=1. On in_valid, capture in_data into the shift register, set idx=0 and go to DRIVE. ack_in and done_in are ignored in IDLE.
- DRIVE:
  - send_out=1; nib_out=shift[3:0], held stable for the whole state.
  - On ack_in=1: at that edge send_out drops to 0, shift right by 4, idx+1, go to GAP.
  - Receiver samples the nibble on that same edge, so nib_out must not change before it.
  - Timer increments each cycle. If it reaches ACK_TIMEOUT with no ack, go to RESP with timeout=1.
- GAP:
  - send_out=0 for at least one cycle. This is mandatory: the receiver re-captures if send stays high.
  - Stay in GAP while ack_in=1; a stale ack is never counted as the next capture.
  - When ack_in=0: if idx==NIBBLES go to WAIT_DONE, else go to DRIVE with the timer cleared.
- WAIT_DONE: send_out=0. On done_in=1, go to RESP with timeout=0. If the timer reaches DONE_TIMEOUT, go to RESP with timeout=1.
- RESP: resp_valid=1 for exactly one cycle, resp_timeout as set. Next state is IDLE. A new word is accepted no earlier than the cycle after RESP.
- Wire ordering: nibble k carries in_data[4k+3:4k]. Minimum transfer is 8 x (DRIVE≥2 + GAP 1) cycles, plus WAIT_DONE.
- Simultaneous ack_in and timeout expiry in the same cycle: ack wins.
- Simultaneous done_in and timeout expiry in the same cycle: done wins.
- in_valid while busy: ignored (in_ready=0); the word is not captured.
- Reset mid-transfer: immediate return to reset values, with send_out=0 asynchronously. The receiver's nibble counter must be reset in the same event; system integration ties both resets together.
- After a timeout abort the receiver may be desynchronised. The master must assert rst before retrying; the block does not resynchronise itself.

Decomposition:
- Shared package nibble_link_pkg:
  - State encoding: IDLE, DRIVE, GAP, WAIT_DONE, RESP.
  - NIBBLE_W=4, NIBBLES_PER_INSN=8, INSN_W=32.
  - Default ACK_TIMEOUT and DONE_TIMEOUT values.
- One natural sub-module, nibble_link_timer: loadable/clearable up-counter with an expiry compare, shared with future receivers.

Test Plan:
- Word 0x1234_ABCD, receiver model acks 1 cycle after send -> nib_out sequence D,C,B,A,4,3,2,1; send_out low ≥1 cycle between nibbles; done_in after 5 cycles -> resp_valid=1, resp_timeout=0; in_ready back to 1 the next cycle.
- ack_in held high 3 cycles after first capture -> block stays in GAP; exactly 8 captures in total and no duplicate nibble D.
- ack_in never asserted, ACK_TIMEOUT=10 -> resp_valid with resp_timeout=1 after 11 DRIVE cycles; send_out=0 afterwards.
- All nibbles acked, done_in never asserted, DONE_TIMEOUT=20 -> resp_timeout=1; done_in asserted in the expiry cycle -> resp_timeout=0.
- rst asserted during nibble 5 -> send_out=0 and in_ready=1 immediately; next word 0xFFFF_0000 transfers correctly from nibble 0.
- in_valid pulsed with 0xDEADBEEF while busy -> ignored; the original word completes unchanged.

Source files
------------

// File: rtl/nibble_link_pkg.sv
// Shared definitions for the 4-bit nibble instruction-load link (transmitter and receivers).
package nibble_link_pkg;

    localparam int NIBBLE_W         = 4;
    localparam int NIBBLES_PER_INSN = 8;
    localparam int INSN_W           = NIBBLE_W * NIBBLES_PER_INSN;

    localparam int ACK_TIMEOUT_DEF  = 255;
    localparam int DONE_TIMEOUT_DEF = 4095;
    localparam int TMR_W_DEF        = 12;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        GAP,
        WAIT_DONE,
        RESP
    } link_state_t;

endpackage

// File: rtl/nibble_link_timer.sv
// Loadable/clearable up-counter with an equality expiry flag against a runtime limit.
module nibble_link_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (inc) begin
            count_reg <= count_reg + W'(1);
        end
    end

    // Expiry is judged on the current count, so the owner sees it in the cycle the limit is reached.
    assign expired = (count_reg == limit);

endmodule

// File: rtl/nibble_insn_tx.sv
// Host-side nibble transmitter: serialises a word LSB-nibble first over send/ack, then waits for done.
module nibble_insn_tx
    import nibble_link_pkg::*;
#(
    parameter int NIBBLES      = NIBBLES_PER_INSN,
    parameter int ACK_TIMEOUT  = ACK_TIMEOUT_DEF,
    parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF,
    parameter int TMR_W        = TMR_W_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  in_data,
    output logic [NIBBLE_W-1:0]          nib_out,
    output logic                         send_out,
    input  logic                         ack_in,
    input  logic                         done_in,
    output logic                         busy,
    output logic                         resp_valid,
    output logic                         resp_timeout
);

    localparam int DATA_W = NIBBLE_W * NIBBLES;
    localparam int IDX_W  = $clog2(NIBBLES + 1);

    link_state_t         state_reg;
    logic [DATA_W-1:0]   shift_reg;
    logic [IDX_W-1:0]    idx_reg;
    logic                send_reg;
    logic                resp_valid_reg;
    logic                resp_timeout_reg;

    logic                tmr_clr;
    logic                tmr_expired;
    logic [TMR_W-1:0]    tmr_limit;

    // The timer only runs in the two waiting states; every other state holds it at zero,
    // so entry into DRIVE or WAIT_DONE always starts from a cleared count.
    assign tmr_clr   = !((state_reg == DRIVE) || (state_reg == WAIT_DONE));
    assign tmr_limit = (state_reg == DRIVE) ? TMR_W'(ACK_TIMEOUT) : TMR_W'(DONE_TIMEOUT);

    nibble_link_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr),
        .load     (1'b0),
        .load_val ({TMR_W{1'b0}}),
        .inc      (!tmr_clr),
        .limit    (tmr_limit),
        .expired  (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            shift_reg        <= '0;
            idx_reg          <= '0;
            send_reg         <= 1'b0;
            resp_valid_reg   <= 1'b0;
            resp_timeout_reg <= 1'b0;
        end else begin
            resp_valid_reg   <= 1'b0;
            resp_timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_data;
                        idx_reg   <= '0;
                        send_reg  <= 1'b1;
                        state_reg <= DRIVE;
                    end
                end
                DRIVE: begin
                    // The receiver samples nib_out on the ack edge, so the shift happens on that same edge.
                    if (ack_in) begin
                        send_reg  <= 1'b0;
                        shift_reg <= shift_reg >> NIBBLE_W;
                        idx_reg   <= idx_reg + IDX_W'(1);
                        state_reg <= GAP;
                    end else if (tmr_expired) begin
                        send_reg         <= 1'b0;
                        resp_valid_reg   <= 1'b1;
                        resp_timeout_reg <= 1'b1;
                        state_reg        <= RESP;
                    end
                end
                GAP: begin
                    // A still-high ack belongs to the previous nibble; wait for it to clear.
                    if (!ack_in) begin
                        if (idx_reg == IDX_W'(NIBBLES)) begin
                            state_reg <= WAIT_DONE;
                        end else begin
                            send_reg  <= 1'b1;
                            state_reg <= DRIVE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (done_in) begin
                        resp_valid_reg <= 1'b1;
                        state_reg      <= RESP;
                    end else if (tmr_expired) begin
                        resp_valid_reg   <= 1'b1;
                        resp_timeout_reg <= 1'b1;
                        state_reg        <= RESP;
                    end
                end
                RESP: begin
                    state_reg <= IDLE;
                end
                default: begin
                    send_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign in_ready     = (state_reg == IDLE);
    assign busy         = (state_reg != IDLE);
    assign send_out     = send_reg;
    assign nib_out      = shift_reg[NIBBLE_W-1:0];
    assign resp_valid   = resp_valid_reg;
    assign resp_timeout = resp_timeout_reg;

endmodule

// File: tb/tb_nibble_insn_tx.sv
// Scoreboard bench for nibble_insn_tx with a behavioural nibble receiver and coprocessor done model.
module tb_nibble_insn_tx;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  nib_out;
    logic        send_out;
    logic        ack_in;
    logic        done_in;
    logic        busy;
    logic        resp_valid;
    logic        resp_timeout;

    nibble_insn_tx #(
        .NIBBLES      (8),
        .ACK_TIMEOUT  (10),
        .DONE_TIMEOUT (20),
        .TMR_W        (12)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .nib_out      (nib_out),
        .send_out     (send_out),
        .ack_in       (ack_in),
        .done_in      (done_in),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_timeout (resp_timeout)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_nib[$];
    bit         exp_resp[$];

    int caps         = 0;
    int drive_cycles = 0;
    int resp_cnt     = 0;

    int ack_delay  = 1;
    int done_delay = 5;
    bit hold_mode  = 0;
    bit hold_used  = 0;
    int hold_left  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Receiver model: acks after the nibble has been presented for ack_delay cycles.
    initial begin : ack_model
        int send_cnt;
        send_cnt = 0;
        ack_in   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                ack_in   = 1'b0;
                send_cnt = 0;
            end else if (send_out && !ack_in) begin
                if (ack_delay >= 0 && send_cnt >= ack_delay) ack_in = 1'b1;
                send_cnt++;
            end else if (!send_out) begin
                send_cnt = 0;
                if (ack_in) begin
                    if (hold_mode && caps == 1 && !hold_used) begin
                        hold_used = 1;
                        hold_left = 3;
                    end
                    if (hold_left > 0) hold_left--;
                    else ack_in = 1'b0;
                end
            end
        end
    end

    // Done model: pulses done_in so the DUT samples it when its wait timer equals done_delay.
    initial begin : done_model
        bit armed;
        int dn;
        armed   = 0;
        dn      = 0;
        done_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            done_in = 1'b0;
            if (rst || caps != 8) begin
                armed = 0;
            end else if (done_delay >= 0) begin
                if (!armed) begin
                    armed = 1;
                    dn    = 0;
                end else begin
                    dn++;
                end
                if (dn == done_delay + 1) done_in = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every receiver capture and every response.
    initial begin : monitor
        bit gap_chk, fresh, rdy_chk, eto;
        logic [3:0] en;
        gap_chk = 0;
        fresh   = 0;
        rdy_chk = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                gap_chk = 0;
                fresh   = 0;
                rdy_chk = 0;
            end else begin
                if (rdy_chk) begin
                    check("in_ready_after_resp", 32'(in_ready), 32'd1);
                    rdy_chk = 0;
                end
                if (gap_chk) begin
                    check("gap_send_low", 32'(send_out), 32'd0);
                    gap_chk = 0;
                end
                if (send_out) drive_cycles++;
                if (send_out && !ack_in) fresh = 1;
                if (send_out && ack_in) begin
                    check("fresh_request", 32'(fresh), 32'd1);
                    fresh = 0;
                    if (exp_nib.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL capture: got unexpected nibble %0h, expected none", nib_out);
                    end else begin
                        en = exp_nib.pop_front();
                        check("nibble", 32'(nib_out), 32'(en));
                    end
                    caps++;
                    gap_chk = 1;
                end
                if (resp_valid) begin
                    if (exp_resp.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL resp: got unexpected response timeout=%0b, expected none", resp_timeout);
                    end else begin
                        eto = exp_resp.pop_front();
                        check("resp_timeout", 32'(resp_timeout), 32'(eto));
                    end
                    check("send_low_at_resp", 32'(send_out), 32'd0);
                    check("in_ready_low_at_resp", 32'(in_ready), 32'd0);
                    $display("[TB] response %0d: timeout=%0b captures=%0d", resp_cnt, resp_timeout, caps);
                    resp_cnt++;
                    rdy_chk = 1;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] w, input bit push_nibs, input bit exp_to);
        int k;
        k = 0;
        while (!in_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        caps         = 0;
        drive_cycles = 0;
        hold_used    = 0;
        hold_left    = 0;
        if (push_nibs) begin
            for (int i = 0; i < 8; i++) exp_nib.push_back(w[4*i +: 4]);
        end
        exp_resp.push_back(exp_to);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
    endtask

    task automatic run_word(input logic [31:0] w, input bit push_nibs, input bit exp_to);
        int start, k;
        start = resp_cnt;
        issue(w, push_nibs, exp_to);
        k = 0;
        while (resp_cnt == start && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (resp_cnt == start) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_wait: no response after %0d cycles, expected one", k);
        end
        @(negedge clk);
        if (push_nibs) check("nibbles_left", 32'(exp_nib.size()), 32'd0);
        exp_nib.delete();
    endtask

    task automatic wait_caps(input int n);
        int k;
        k = 0;
        while (caps < n && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (caps < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_caps: got %0d captures, expected %0d", caps, n);
        end
    endtask

    task automatic pulse_busy();
        @(posedge clk);
        @(posedge clk);
        wait_caps(2);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        exp_nib.delete();
        exp_resp.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_send_out", 32'(send_out), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        check("rst_nib_out", 32'(nib_out), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Basic transfer: nibbles D,C,B,A,4,3,2,1 then done.
        run_word(32'h1234_ABCD, 1, 0);

        // Stale ack held through GAP must not create an extra capture.
        hold_mode = 1;
        run_word(32'h1234_ABCD, 1, 0);
        check("hold_total_caps", 32'(caps), 32'd8);
        hold_mode = 0;

        // Ack arriving in the ack-expiry cycle wins; done in first wait cycle.
        ack_delay  = 10;
        done_delay = 0;
        run_word(32'h0A1B_2C3D, 1, 0);
        ack_delay  = 1;
        done_delay = 5;

        // No ack at all: timeout after 11 DRIVE cycles.
        ack_delay = -1;
        run_word(32'hCAFE_F00D, 0, 1);
        check("ack_to_drive_cycles", 32'(drive_cycles), 32'd11);
        check("ack_to_send_low", 32'(send_out), 32'd0);
        ack_delay = 1;
        do_reset();

        // Done never arrives: done timeout.
        done_delay = -1;
        run_word(32'h55AA_33CC, 1, 1);
        check("done_to_caps", 32'(caps), 32'd8);
        do_reset();

        // Done in the done-expiry cycle wins.
        done_delay = 20;
        run_word(32'h1357_2468, 1, 0);
        done_delay = 5;

        // New word offered while busy is ignored.
        fork
            run_word(32'h89AB_CDEF, 1, 0);
            pulse_busy();
        join

        // Reset while nibble 5 is being driven, then a clean transfer.
        issue(32'h7654_3210, 1, 0);
        wait_caps(5);
        @(posedge clk);
        @(posedge clk);
        #3;
        check("nib5_send_high", 32'(send_out), 32'd1);
        check("nib5_value", 32'(nib_out), 32'h5);
        rst = 1'b1;
        #1;
        check("midrst_send_low", 32'(send_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_nib_out", 32'(nib_out), 32'd0);
        exp_nib.delete();
        exp_resp.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        run_word(32'hFFFF_0000, 1, 0);

        check("resp_count", 32'(resp_cnt), 32'd8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
